// File: rtl/gate_controller.sv
// Gate-window sequencer for the frequency-meter edge counter: ARM -> GATE -> SETTLE -> DONE with a valid/ready result.
// Optional counter-wrap detection during the gate is built when GATE_CTRL_OVF_EN is defined; otherwise result_ovf is 0.
module gate_controller #(
   parameter int GW            = 24,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          continuous,
   input  logic          abort,
   input  logic [GW-1:0] gate_len,
   input  logic [31:0]   count_in,
   output logic          cnt_en,
   output logic [31:0]   result,
   output logic          result_valid,
   input  logic          result_ready,
   output logic          result_ovf,
   output logic          busy
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_GATE,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t          state_q;
   logic            cnt_en_q;
   logic [31:0]     result_q;
   logic            result_valid_q;
   logic [GW-1:0]   gate_cnt_q;
   logic [SW-1:0]   settle_cnt_q;
   logic            cont_q;
   logic [GW-1:0]   gate_len_d;

`ifdef GATE_CTRL_OVF_EN
   logic [31:0]     prev_q;
   logic            wrap_q;
   logic            result_ovf_q;
`endif

   // A zero gate length still opens a one-cycle window.
   assign gate_len_d = (gate_len == '0) ? GW'(1) : gate_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_en_q       <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         gate_cnt_q     <= '0;
         settle_cnt_q   <= '0;
         cont_q         <= 1'b0;
`ifdef GATE_CTRL_OVF_EN
         prev_q         <= '0;
         wrap_q         <= 1'b0;
         result_ovf_q   <= 1'b0;
`endif
      end else begin
         // Enable lags the GATE state by one cycle; abort must drop it at once.
         cnt_en_q <= (state_q == S_GATE) && !abort;
         if (abort) begin
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
`ifdef GATE_CTRL_OVF_EN
            wrap_q         <= 1'b0;
            result_ovf_q   <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     state_q    <= S_ARM;
                     gate_cnt_q <= gate_len_d;
                     cont_q     <= continuous;
                  end
               end
               S_ARM: begin
                  state_q <= S_GATE;
`ifdef GATE_CTRL_OVF_EN
                  wrap_q  <= 1'b0;
                  prev_q  <= count_in;
`endif
               end
               S_GATE: begin
`ifdef GATE_CTRL_OVF_EN
                  if (count_in < prev_q) begin
                     wrap_q <= 1'b1;
                  end
                  prev_q <= count_in;
`endif
                  gate_cnt_q <= gate_cnt_q - GW'(1);
                  if (gate_cnt_q == GW'(1)) begin
                     state_q      <= S_SETTLE;
                     settle_cnt_q <= SW'(SETTLE_CYCLES);
                  end
               end
               S_SETTLE: begin
                  // Counts SETTLE_CYCLES..0 so capture lands SETTLE_CYCLES cycles after cnt_en falls.
                  if (settle_cnt_q == '0) begin
                     state_q        <= S_DONE;
                     result_q       <= count_in;
                     result_valid_q <= 1'b1;
`ifdef GATE_CTRL_OVF_EN
                     result_ovf_q   <= wrap_q;
`endif
                  end else begin
                     settle_cnt_q <= settle_cnt_q - SW'(1);
                  end
               end
               S_DONE: begin
                  if (result_ready) begin
                     result_valid_q <= 1'b0;
`ifdef GATE_CTRL_OVF_EN
                     wrap_q         <= 1'b0;
                     result_ovf_q   <= 1'b0;
`endif
                     if (cont_q) begin
                        state_q    <= S_ARM;
                        gate_cnt_q <= gate_len_d;
                        cont_q     <= continuous;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign cnt_en       = cnt_en_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign busy         = (state_q != S_IDLE);
`ifdef GATE_CTRL_OVF_EN
   assign result_ovf   = result_ovf_q;
`else
   assign result_ovf   = 1'b0;
`endif

endmodule
